// File: rtl/md6_tree_sched.sv
// md6_tree_sched
//
// Sequencer for a single MD6 compression-function (cf) datapath in tree mode
// with 4:1 compression. A job names the leaf count (last_leaf + 1) and the
// padding of the last leaf block. The block then issues one cf operation at a
// time, level by level, until the root. It holds no hash data: it only drives
// the cf control inputs and the addresses of the message store and the
// ping-pong chaining-value RAM.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           one-cycle job request, sampled only in IDLE
//   last_leaf       number of leaves minus 1
//   msg_pad         padding-zero bit count of the last leaf block
//   cf_done         cf completion, sampled only in RUN
//   busy            high from the cycle after an accepted start until job_done
//   job_done        one-cycle pulse after the root result is written
//   cf_reset        one-cycle clear of the cf before each operation
//   cf_enable       high while the cf computes
//   cf_index        node index within the level (zero-extended)
//   cf_index_padd   last index of the current level
//   cf_level        current level, leaves are level 1
//   cf_height       total tree height of the job
//   cf_z_end        1 on the root operation
//   cf_pad          padding-zero bits of the current operation
//   src_is_msg      cf input comes from the message store (level 1)
//   src_addr        message block number, or {bank, first child address}
//   wr_en           one-cycle write strobe for the cf result
//   wr_addr         {bank, node index} destination in the chaining RAM
module md6_tree_sched #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] last_leaf,
    input  logic [15:0]   msg_pad,
    input  logic          cf_done,
    output logic          busy,
    output logic          job_done,
    output logic          cf_reset,
    output logic          cf_enable,
    output logic [55:0]   cf_index,
    output logic [7:0]    cf_index_padd,
    output logic [7:0]    cf_level,
    output logic [7:0]    cf_height,
    output logic [3:0]    cf_z_end,
    output logic [15:0]   cf_pad,
    output logic          src_is_msg,
    output logic [AW:0]   src_addr,
    output logic          wr_en,
    output logic [AW:0]   wr_addr
);

    typedef enum logic [2:0] {IDLE, CLR, RUN, STORE, NEXT, FIN} state_t;

    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_THREE = 3;
    localparam logic [AW-1:0] IDX_ONE   = 1;

    state_t        state, state_n;
    logic [7:0]    level, level_n;
    logic [AW-1:0] index, index_n;
    logic [AW:0]   cnt, cnt_n;
    logic [AW:0]   prev_cnt, prev_cnt_n;
    logic [7:0]    height, height_n;
    logic [AW-1:0] last_r, last_n;
    logic [15:0]   pad_r, pad_n;

    logic [AW+1:0] rem;
    logic [15:0]   op_pad;
    logic [AW:0]   op_src;

    // Height = 1 + number of ceil(/4) steps from the leaf count down to 1.
    function automatic logic [7:0] tree_height(input logic [AW-1:0] ll);
        if (ll == '0)               return 8'd1;
        else if (ll[AW-1:2] == '0)  return 8'd2;
        else if (ll[AW-1:4] == '0)  return 8'd3;
        else if (ll[AW-1:6] == '0)  return 8'd4;
        else                        return 8'd5;
    endfunction

    // Next-state and next-job-context logic.
    always_comb begin
        state_n    = state;
        level_n    = level;
        index_n    = index;
        cnt_n      = cnt;
        prev_cnt_n = prev_cnt;
        height_n   = height;
        last_n     = last_r;
        pad_n      = pad_r;
        case (state)
            IDLE: begin
                if (start) begin
                    level_n    = 8'd1;
                    index_n    = '0;
                    cnt_n      = {1'b0, last_leaf} + CNT_ONE;
                    prev_cnt_n = '0;
                    height_n   = tree_height(last_leaf);
                    last_n     = last_leaf;
                    pad_n      = msg_pad;
                    state_n    = CLR;
                end
            end
            CLR:   state_n = RUN;
            RUN:   if (cf_done) state_n = STORE;
            STORE: state_n = NEXT;
            NEXT: begin
                if (cnt == CNT_ONE) begin
                    state_n = FIN;
                end else if ({1'b0, index} == cnt - CNT_ONE) begin
                    level_n    = level + 8'd1;
                    prev_cnt_n = cnt;
                    cnt_n      = (cnt + CNT_THREE) >> 2;
                    index_n    = '0;
                    state_n    = CLR;
                end else begin
                    index_n = index + IDX_ONE;
                    state_n = CLR;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand address and padding for the operation about to start. Above
    // level 1 a node reads four children from the bank the previous level
    // wrote; the last node of a level may have fewer than four real children,
    // and each missing child counts as 1024 padding bits.
    always_comb begin
        rem = {1'b0, prev_cnt_n} - {index_n, 2'b00};
        if (level_n == 8'd1) begin
            op_pad = (index_n == last_n) ? pad_n : 16'd0;
            op_src = {1'b0, index_n};
        end else begin
            op_pad = (rem[AW+1:2] != '0) ? 16'd0
                                         : {4'd0, 2'(3'd4 - rem[2:0]), 10'd0};
            op_src = {~level_n[0], index_n[AW-3:0], 2'b00};
        end
    end

    // State, job context and registered outputs. The operation outputs are
    // loaded on entry to CLR so they hold steady through STORE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            level         <= '0;
            index         <= '0;
            cnt           <= '0;
            prev_cnt      <= '0;
            height        <= '0;
            last_r        <= '0;
            pad_r         <= '0;
            busy          <= 1'b0;
            job_done      <= 1'b0;
            cf_reset      <= 1'b0;
            cf_enable     <= 1'b0;
            wr_en         <= 1'b0;
            cf_index      <= '0;
            cf_index_padd <= '0;
            cf_level      <= '0;
            cf_height     <= '0;
            cf_z_end      <= '0;
            cf_pad        <= '0;
            src_is_msg    <= 1'b0;
            src_addr      <= '0;
            wr_addr       <= '0;
        end else begin
            state     <= state_n;
            level     <= level_n;
            index     <= index_n;
            cnt       <= cnt_n;
            prev_cnt  <= prev_cnt_n;
            height    <= height_n;
            last_r    <= last_n;
            pad_r     <= pad_n;
            busy      <= (state_n != IDLE);
            job_done  <= (state_n == FIN);
            cf_reset  <= (state_n == CLR);
            cf_enable <= (state_n == RUN);
            wr_en     <= (state_n == STORE);
            if (state_n == CLR) begin
                cf_index      <= {{(56-AW){1'b0}}, index_n};
                cf_index_padd <= 8'(cnt_n - CNT_ONE);
                cf_level      <= level_n;
                cf_height     <= height_n;
                cf_z_end      <= (cnt_n == CNT_ONE) ? 4'd1 : 4'd0;
                cf_pad        <= op_pad;
                src_is_msg    <= (level_n == 8'd1);
                src_addr      <= op_src;
                wr_addr       <= {level_n[0], index_n};
            end
        end
    end

endmodule

// File: tb/tb_md6_tree_sched.sv
// tb_md6_tree_sched
//
// Scoreboard bench for md6_tree_sched. Job stimulus pushes the expected cf
// operations into a queue; a monitor process pops one entry per wr_en pulse
// and compares the operation outputs. A cf model answers each cf_reset with a
// cf_done pulse after a programmable latency.
module tb_md6_tree_sched;

    typedef struct packed {
        logic [7:0]  level;
        logic [7:0]  index;
        logic [3:0]  z;
        logic [15:0] pad;
        logic        sim;
        logic [8:0]  src;
        logic [8:0]  wr;
        logic [7:0]  h;
        logic [7:0]  padd;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  last_leaf;
    logic [15:0] msg_pad;
    logic        cf_done;
    logic        busy, job_done, cf_reset, cf_enable, src_is_msg, wr_en;
    logic [55:0] cf_index;
    logic [7:0]  cf_index_padd, cf_level, cf_height;
    logic [3:0]  cf_z_end;
    logic [15:0] cf_pad;
    logic [8:0]  src_addr, wr_addr;

    int   checks = 0;
    int   errors = 0;
    int   wr_seen = 0;
    int   done_seen = 0;
    int   jobs_pending = 0;
    int   cf_lat = 1;
    op_t  exp_q[$];
    op_t  snap;

    always #5 clk = ~clk;

    md6_tree_sched #(.AW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .last_leaf(last_leaf),
        .msg_pad(msg_pad), .cf_done(cf_done), .busy(busy), .job_done(job_done),
        .cf_reset(cf_reset), .cf_enable(cf_enable), .cf_index(cf_index),
        .cf_index_padd(cf_index_padd), .cf_level(cf_level),
        .cf_height(cf_height), .cf_z_end(cf_z_end), .cf_pad(cf_pad),
        .src_is_msg(src_is_msg), .src_addr(src_addr), .wr_en(wr_en),
        .wr_addr(wr_addr)
    );

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic op_t curOp();
        op_t o;
        o.level = cf_level;  o.index = cf_index[7:0]; o.z = cf_z_end;
        o.pad = cf_pad;      o.sim = src_is_msg;      o.src = src_addr;
        o.wr = wr_addr;      o.h = cf_height;         o.padd = cf_index_padd;
        return o;
    endfunction

    function automatic logic [63:0] ctrlOut();
        return {12'd0, busy, job_done, cf_reset, cf_enable, wr_en, src_is_msg,
                cf_z_end, cf_level, cf_height, cf_index_padd, src_addr, wr_addr};
    endfunction

    task automatic pushOp(input int lvl, input int idx, input int z,
                          input int pad, input int sim, input int src,
                          input int wr, input int h, input int padd);
        op_t o;
        o.level = 8'(lvl); o.index = 8'(idx); o.z = 4'(z); o.pad = 16'(pad);
        o.sim = 1'(sim);   o.src = 9'(src);   o.wr = 9'(wr); o.h = 8'(h);
        o.padd = 8'(padd);
        exp_q.push_back(o);
    endtask

    // Reference tree walk used for the large job.
    task automatic pushModel(input int ll, input int mpad);
        int cnt, lvl, prev, h, n, pad, src, rem;
        cnt = ll + 1; lvl = 1; prev = 0; h = 1; n = cnt;
        while (n > 1) begin n = (n + 3) / 4; h++; end
        while (1) begin
            for (int i = 0; i < cnt; i++) begin
                if (lvl == 1) begin
                    pad = (i == ll) ? mpad : 0;
                    src = i;
                end else begin
                    rem = prev - 4 * i;
                    pad = (rem >= 4) ? 0 : (4 - rem) * 1024;
                    src = ((lvl % 2 == 0) ? 256 : 0) + ((4 * i) % 256);
                end
                pushOp(lvl, i, (cnt == 1) ? 1 : 0, pad, (lvl == 1) ? 1 : 0,
                       src, ((lvl % 2 == 1) ? 256 : 0) + i, h, cnt - 1);
            end
            if (cnt == 1) break;
            prev = cnt; cnt = (cnt + 3) / 4; lvl++;
        end
    endtask

    task automatic pushFiveLeafL1();
        for (int i = 0; i < 5; i++)
            pushOp(1, i, 0, (i == 4) ? 100 : 0, 1, i, 'h100 + i, 3, 4);
    endtask

    task automatic applyStimulus(input int ll, input int pad);
        @(negedge clk);
        start = 1'b1; last_leaf = 8'(ll); msg_pad = 16'(pad);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("cf_reset_after_start", cf_reset, 1);
    endtask

    task automatic waitJobDone(input int budget);
        int n = 0;
        while (!job_done && n < budget) begin @(negedge clk); n++; end
        if (!job_done) begin
            checkOutput("job_done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            checkOutput("busy_after_done", busy, 0);
        end
    endtask

    // cf model: cf_done pulses cf_lat cycles after the cf_reset cycle.
    initial begin
        cf_done = 1'b0;
        forever begin
            @(negedge clk);
            if (cf_reset) begin
                repeat (cf_lat) @(negedge clk);
                cf_done = 1'b1;
                @(negedge clk);
                cf_done = 1'b0;
            end
        end
    end

    // Monitor: pops one expected operation per write strobe.
    initial begin
        op_t e;
        snap = '0;
        forever begin
            @(negedge clk);
            if (cf_reset) snap = curOp();
            if (wr_en) begin
                wr_seen++;
                checkOutput("op_stable_clr_to_store", curOp(), snap);
                checkOutput("op_index_high_bits", cf_index[55:8], 0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_wr_en", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("op_fields", curOp(), e);
                end
            end
            if (job_done) begin
                done_seen++;
                if (jobs_pending == 0) begin
                    checkOutput("unexpected_job_done", 1, 0);
                end else begin
                    jobs_pending--;
                    checkOutput("ops_left_at_job_done", exp_q.size(), 0);
                end
            end
        end
    end

    initial begin
        int w0, n;
        reset = 1'b1; start = 1'b0; last_leaf = '0; msg_pad = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl_outputs", ctrlOut(), 0);
        checkOutput("reset_cf_index", cf_index, 0);
        checkOutput("reset_cf_pad", cf_pad, 0);
        reset = 1'b0;

        // 1 leaf, cf_done accepted in the cycle RUN is entered
        cf_lat = 1;
        pushOp(1, 0, 1, 512, 1, 'h000, 'h100, 1, 0);
        jobs_pending++;
        applyStimulus(0, 512);
        waitJobDone(50);

        // 5 leaves: three levels
        pushFiveLeafL1();
        pushOp(2, 0, 0, 0,    0, 'h100, 'h000, 3, 1);
        pushOp(2, 1, 0, 3072, 0, 'h104, 'h001, 3, 1);
        pushOp(3, 0, 1, 2048, 0, 'h000, 'h100, 3, 0);
        jobs_pending++;
        applyStimulus(4, 100);
        waitJobDone(200);

        // 256 leaves, 3-cycle cf
        cf_lat = 3;
        w0 = wr_seen;
        pushModel(255, 'h40);
        jobs_pending++;
        applyStimulus(255, 'h40);
        waitJobDone(5000);
        checkOutput("wr_count_256", wr_seen - w0, 341);

        // reset during RUN of L2 i0: the in-flight result must be dropped
        cf_lat = 4;
        w0 = wr_seen;
        pushFiveLeafL1();
        applyStimulus(4, 100);
        n = 0;
        while (!((wr_seen - w0) == 5 && cf_enable) && n < 300) begin
            @(negedge clk); n++;
        end
        checkOutput("reached_l2_run", {cf_enable, cf_level}, {1'b1, 8'd2});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("outputs_after_reset", ctrlOut(), 0);
        checkOutput("cf_index_after_reset", cf_index, 0);
        checkOutput("cf_pad_after_reset", cf_pad, 0);
        repeat (12) @(negedge clk);
        checkOutput("wr_count_reset_job", wr_seen - w0, 5);

        // new 1-leaf job after reset
        cf_lat = 2;
        pushOp(1, 0, 1, 7, 1, 'h000, 'h100, 1, 0);
        jobs_pending++;
        applyStimulus(0, 7);
        waitJobDone(50);

        // 4 leaves with a stray start during RUN
        cf_lat = 3;
        w0 = wr_seen;
        for (int i = 0; i < 4; i++)
            pushOp(1, i, 0, (i == 3) ? 'h200 : 0, 1, i, 'h100 + i, 2, 3);
        pushOp(2, 0, 1, 0, 0, 'h100, 'h000, 2, 0);
        jobs_pending++;
        applyStimulus(3, 'h200);
        n = 0;
        while (!cf_enable && n < 20) begin @(negedge clk); n++; end
        start = 1'b1; last_leaf = 8'd9; msg_pad = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        waitJobDone(200);
        repeat (10) @(negedge clk);
        checkOutput("wr_count_4_leaf", wr_seen - w0, 5);
        checkOutput("job_done_total", done_seen, 5);
        checkOutput("idle_at_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
